// File: rtl/pgmap_stat_wb.sv
// Page-map statistics write-back sequencer: {acc,mod} read-modify-write per qualified CPU cycle,
// plus a low-priority scan/clear port. Optional build macro: PGSTAT_SKIP_CLEAN_WB_EN.
module pgmap_stat_wb #(
    parameter int unsigned PAGE_W = 12,
    parameter int unsigned DROP_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cyc_valid,
    input  logic              cyc_read,
    input  logic [1:0]        cyc_fc,
    input  logic              cyc_back,
    input  logic              booten,
    input  logic [PAGE_W-1:0] cyc_page,
    output logic [PAGE_W-1:0] map_addr,
    output logic              map_rd,
    input  logic [1:0]        map_rdata,
    output logic              map_wr,
    output logic [1:0]        map_wdata,
    input  logic              scan_req,
    input  logic [PAGE_W-1:0] scan_page,
    input  logic              scan_clear,
    output logic              scan_ack,
    output logic              scan_acc,
    output logic              scan_mod,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {StIdle, StRd, StWb, StSrd, StSwb} state_e;

    state_e            state_q;
    logic [PAGE_W-1:0] act_page_q;
    logic              act_read_q;
    logic              pend_v_q;
    logic [PAGE_W-1:0] pend_page_q;
    logic              pend_read_q;
    logic [PAGE_W-1:0] scan_page_q;
    logic [DROP_W-1:0] drop_q;
    logic              cyc_qual;
    logic [1:0]        wb_data;

    // MMU table references, refresh cycles and the boot state never touch statistics.
    assign cyc_qual = cyc_valid & ~booten
                    & ~((cyc_fc == 2'b11) & ~cyc_back)
                    & ~(cyc_fc[1] & cyc_back);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            act_page_q  <= '0;
            act_read_q  <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_page_q <= '0;
            pend_read_q <= 1'b0;
            scan_page_q <= '0;
            drop_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pend_v_q) begin
                        state_q     <= StRd;
                        act_page_q  <= pend_page_q;
                        act_read_q  <= pend_read_q;
                        pend_v_q    <= cyc_qual;
                        if (cyc_qual) begin
                            pend_page_q <= cyc_page;
                            pend_read_q <= cyc_read;
                        end
                    end else if (cyc_qual) begin
                        state_q    <= StRd;
                        act_page_q <= cyc_page;
                        act_read_q <= cyc_read;
                    end else if (scan_req) begin
                        state_q     <= StSrd;
                        scan_page_q <= scan_page;
                    end
                end
                StRd:    state_q <= StWb;
                StWb:    state_q <= StIdle;
                StSrd:   state_q <= StSwb;
                StSwb:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // While a sequence is in flight only one further event can be parked.
            if ((state_q != StIdle) && cyc_qual) begin
                if (!pend_v_q) begin
                    pend_v_q    <= 1'b1;
                    pend_page_q <= cyc_page;
                    pend_read_q <= cyc_read;
                end else if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    always_comb begin
        map_addr  = '0;
        map_rd    = 1'b0;
        map_wr    = 1'b0;
        map_wdata = 2'b00;
        scan_ack  = 1'b0;
        scan_acc  = 1'b0;
        scan_mod  = 1'b0;
        wb_data   = {1'b1, map_rdata[0] | ~act_read_q};
        // Strobes are masked in a reset cycle so an interrupted WB/SWB never writes.
        if (!RESET) begin
            case (state_q)
                StRd: begin
                    map_rd   = 1'b1;
                    map_addr = act_page_q;
                end
                StWb: begin
                    map_addr  = act_page_q;
                    map_wdata = wb_data;
`ifdef PGSTAT_SKIP_CLEAN_WB_EN
                    map_wr    = (wb_data != map_rdata);
`else
                    map_wr    = 1'b1;
`endif
                end
                StSrd: begin
                    map_rd   = 1'b1;
                    map_addr = scan_page_q;
                end
                StSwb: begin
                    scan_ack  = 1'b1;
                    scan_acc  = map_rdata[1];
                    scan_mod  = map_rdata[0];
                    map_addr  = scan_page_q;
                    map_wr    = scan_clear;
                    map_wdata = 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign busy     = ~RESET & ((state_q != StIdle) | pend_v_q);
    assign drop_cnt = drop_q;

endmodule

// File: doc/pgmap_stat_wb.md
Name: pgmap_stat_wb

Overview:
Page-map statistics write-back sequencer for the 120 CPU board. Each qualified CPU memory cycle triggers a read-modify-write of the accessed/modified bits for that page in the page-map statistics RAM. A low-priority scan port lets the kernel read a page's statistics and optionally clear them. Sits between the CPU cycle decoder and the page-map RAM; it owns the RAM's statistics port.

Parameters:
PAGE_W, 12, page-map index width
DROP_W, 8, width of saturating dropped-event counter

Ports:
CLK  in  1  board clock; all logic rising-edge
RESET  in  1  synchronous, active-high reset
cyc_valid  in  1  one-cycle strobe: CPU cycle reached stat point
cyc_read  in  1  1 = read cycle, 0 = write cycle
cyc_fc  in  2  p.fc1,p.fc0 function-code bits of the cycle
cyc_back  in  1  refresh/back cycle marker (p.back)
booten  in  1  boot state active; statistics frozen
cyc_page  in  PAGE_W  page index of the cycle
map_addr  out  PAGE_W  stat RAM address
map_rd  out  1  stat RAM read strobe; data valid next cycle
map_rdata  in  2  {acc,mod} from RAM
map_wr  out  1  stat RAM write strobe
map_wdata  out  2  {acc,mod} to RAM
scan_req  in  1  level; held until scan_ack
scan_page  in  PAGE_W  page to scan
scan_clear  in  1  clear acc/mod after read
scan_ack  out  1  one-cycle pulse; scan_acc/scan_mod valid
scan_acc  out  1  sampled acc
scan_mod  out  1  sampled mod
busy  out  1  FSM not IDLE or pending slot full
drop_cnt  out  DROP_W  events lost to overflow, saturating

Behaviour:
- Disable: the event is ignored if (fc==2'b11 & ~cyc_back) [mmu ref], (fc[1] & cyc_back) [refresh], or booten. Ignored events do not occupy the pending slot or count as drops.
- States: IDLE, RD, WB, SRD, SWB.
- IDLE: if pend_v, load pend into active and go to RD. In the same cycle, a qualified cyc_valid goes into pend. Otherwise a qualified cyc_valid loads active directly and goes to RD. Otherwise, if scan_req, go to SRD. CPU events always win over scan.
- RD: map_rd=1, map_addr=active page; go to WB.
- WB: map_wr=1, map_addr=active page, map_wdata={1, map_rdata.mod | ~active_read}; go to IDLE.
- SRD: map_rd=1, map_addr=scan_page; go to SWB.
- SWB: scan_ack=1, scan_acc/scan_mod=map_rdata. If scan_clear, map_wr=1 with wdata 2'b00. Go to IDLE.
- Latency: qualified event accepted in cycle N (IDLE) gives map_rd at N+1, map_wr at N+2, IDLE at N+3.
- Qualified cyc_valid while not IDLE: stored in pend if empty. If pend is already full, the event is dropped and drop_cnt increments, saturating at all-ones.
- RAM ordering: a write in cycle N is visible to a read issued at N+1. Same-page back-to-back events are therefore coherent.
- map_rd and map_wr are never both asserted. map_addr=0 when idle.
- Reset (any state, including mid RD/WB/SWB): state=IDLE, pend_v=0, drop_cnt=0, all strobes and scan_ack 0, scan_acc/scan_mod 0, busy 0. No map_wr in a reset cycle. A scan_req still high after reset is re-serviced from SRD.
- busy = (state!=IDLE) | pend_v.

Optional Feature:
PGSTAT_SKIP_CLEAN_WB_EN.
- Defined: in WB, map_wr is suppressed when the computed wdata equals map_rdata (already acc=1 and mod unchanged). FSM timing is unchanged.
- Undefined: WB always writes.
- Scan clear always writes in both builds.

Test Plan:
1. Read event, page 0x012, RAM=00 -> map_rd at N+1 addr 0x012; map_wr at N+2, wdata=2'b10; busy low at N+3.
2. Write event, page 0x345, RAM=10 -> map_wr wdata=2'b11. Then a read event to the same page -> wdata stays 11 (mod preserved).
3. Events with fc=11/back=0, fc=10/back=1, booten=1 -> no map_rd, busy=0, drop_cnt=0.
4. Qualified events in cycles N, N+1, N+2 -> first serviced N+1/N+2, second pending then map_rd at N+4, third dropped, drop_cnt=1. After 2^DROP_W+5 overflows, drop_cnt=all-ones.
5. scan_req page 0x345, scan_clear=1, RAM=11, asserted in the same cycle as a cyc_valid to 0x001 -> CPU RMW first; then SRD, scan_ack with acc=1 mod=1, map_wr wdata=00. The next scan of the same page reads 00.
6. RESET asserted during WB -> no map_wr that cycle; pend cleared; drop_cnt=0. With PGSTAT_SKIP_CLEAN_WB_EN, a read event to a page holding 10 -> map_rd but no map_wr.
